filt_arb: RTL
=============

FILT_ARB -- requirements
Module: filt_arb

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of filter channels served (2..8).
REQ-002 The block SHALL have port SYSCLK  input  1  system clock; all logic SHALL use its rising edge.
REQ-003 The block SHALL have port SYSRSTn  input  1  system reset, asynchronous, active-low.
REQ-004 The block SHALL have port ch_data_in  input  32*NCH  filter outputs; channel i occupies bits [32i+31:32i].
REQ-005 The block SHALL have port ch_update_in  input  NCH  per-channel data-update pulse, one SYSCLK cycle wide.
REQ-006 The block SHALL have port reg_chen  input  NCH  per-channel arbitration enable.
REQ-007 The block SHALL have port reg_ovfclr  input  NCH  write-1-to-clear pulse for overflow flags.
REQ-008 The block SHALL have port out_data  output  32  granted channel data.
REQ-009 The block SHALL have port out_ch  output  3  granted channel index.
REQ-010 The block SHALL have port out_valid  output  1  out_data/out_ch valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts the word this cycle.
REQ-012 The block SHALL have port ovf_flags  output  NCH  sticky per-channel overrun flags.
REQ-013 The block SHALL have port irq  output  1  interrupt = OR of ovf_flags.

Function
REQ-014 Per channel: 32-bit hold register and pending bit; ch_update_in[i] & reg_chen[i] SHALL capture ch_data_in channel i and set pending[i] at the next edge.
REQ-015 Update on channel i while pending[i]=1 and not granted that cycle SHALL overwrite the hold register and set ovf_flags[i].
REQ-016 Update on channel i in the same cycle channel i is granted SHALL present the old data, capture the new data, and keep pending[i]=1, with no overflow.
REQ-017 Output FSM SHALL have states IDLE (out_valid=0) and VALID (out_valid=1).
REQ-018 IDLE -> VALID when any pending bit is set: the winning channel's data and index SHALL load into out_data/out_ch and its pending bit SHALL clear at the same edge.
REQ-019 VALID with out_ready=1: if another pending bit is set, SHALL stay VALID and load the next winner at that edge (back-to-back, no bubble); else -> IDLE.
REQ-020 VALID with out_ready=0: out_data, out_ch SHALL hold stable.
REQ-021 Winner SHALL be chosen round-robin: search starts at (last granted index + 1) mod NCH, ascending with wrap; last granted resets to NCH-1 so channel 0 wins first.
REQ-022 Latency: update pulse in cycle N -> pending in N+1 -> out_valid in N+2 when IDLE and no other pending.
REQ-023 reg_chen[i]=0 SHALL clear pending[i] at the next edge and suppress capture; a word already in the output register SHALL still be delivered.
REQ-024 ovf_flags[i] SHALL clear on reg_ovfclr[i]=1; simultaneous set and clear SHALL leave the flag set.
REQ-025 irq SHALL be registered-free: combinational OR of ovf_flags.

Reset
REQ-026 SYSRSTn=0 SHALL asynchronously force: FSM IDLE, out_valid=0, out_data=0, out_ch=0, all pending=0, hold registers=0, ovf_flags=0, irq=0, last granted=NCH-1.
REQ-027 Reset asserted mid-transfer SHALL discard the output word and all pending data; no word SHALL be emitted after release until a new update pulse.

Verification
REQ-028 Single update ch2, data 0x0000_1234, out_ready=1 -> out_valid two cycles later, out_data=0x0000_1234, out_ch=2, one cycle valid.
REQ-029 Simultaneous updates ch0..ch3 (data 0xA0..0xA3), out_ready=1 -> four consecutive words, order ch0,1,2,3, no bubble; next burst starts at ch0 again after last=3.
REQ-030 ch1 updated twice (0x11 then 0x22) with out_ready=0 -> ovf_flags=0b0010, irq=1; on ready, delivers 0x22; reg_ovfclr[1] pulse -> ovf_flags=0, irq=0.
REQ-031 out_ready held 0 for 10 cycles with word valid -> out_data/out_ch unchanged throughout; release -> accepted, next pending follows next cycle.
REQ-032 Update ch0 coincident with ch0 grant -> old word out, new word pending, ovf_flags[0]=0, second word delivered next.
REQ-033 reg_chen[3]=0 with ch3 pending -> pending dropped, no ch3 word; SYSRSTn pulse while out_valid=1 -> all outputs 0 immediately, no output after release.

Source files
------------

// File: rtl/filt_arb.sv
// filt_arb: round-robin arbiter that collects words from NCH filter channels
// and delivers them one at a time on a valid/ready output port.
//
// Each channel has a 32-bit hold register and a pending bit. An update pulse
// on an enabled channel captures that channel's data. The arbiter grants
// pending channels round-robin into a single output register.
//
// Ports:
//   SYSCLK        system clock (rising edge)
//   SYSRSTn       asynchronous active-low reset
//   ch_data_in    NCH x 32-bit filter outputs; channel i at [32i+31:32i]
//   ch_update_in  per-channel one-cycle update pulse
//   reg_chen      per-channel arbitration enable
//   reg_ovfclr    per-channel write-1-to-clear for ovf_flags
//   out_data      granted channel data
//   out_ch        granted channel index
//   out_valid     out_data/out_ch valid
//   out_ready     consumer accepts the word this cycle
//   ovf_flags     sticky per-channel overrun flags
//   irq           OR of ovf_flags
module filt_arb #(
  parameter int NCH = 4
) (
  input  logic              SYSCLK,
  input  logic              SYSRSTn,
  input  logic [32*NCH-1:0] ch_data_in,
  input  logic [NCH-1:0]    ch_update_in,
  input  logic [NCH-1:0]    reg_chen,
  input  logic [NCH-1:0]    reg_ovfclr,
  output logic [31:0]       out_data,
  output logic [2:0]        out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH-1:0]    ovf_flags,
  output logic              irq
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;
  // Last-granted starts at the top channel so channel 0 wins the first search.
  localparam logic [2:0] LAST_RST = 3'(NCH - 1);

  logic [0:0]     state_r;
  logic [31:0]    hold_r [NCH];
  logic [NCH-1:0] pending_r;
  logic [NCH-1:0] ovf_r;
  logic [2:0]     last_r;
  logic [31:0]    out_data_r;
  logic [2:0]     out_ch_r;

  logic [NCH-1:0] elig_s;
  logic           hi_found_s;
  logic [2:0]     hi_idx_s;
  logic           any_elig_s;
  logic [2:0]     lo_idx_s;
  logic [2:0]     win_idx_s;
  logic [NCH-1:0] win_onehot_s;
  logic [31:0]    win_data_s;
  logic           grant_s;
  logic [NCH-1:0] grant_vec_s;
  logic [NCH-1:0] upd_s;
  logic [NCH-1:0] ovf_set_s;

  // Round-robin search: lowest eligible index above last_r, else lowest eligible overall.
  always_comb begin
    elig_s     = pending_r & reg_chen;
    hi_found_s = 1'b0;
    hi_idx_s   = 3'd0;
    any_elig_s = 1'b0;
    lo_idx_s   = 3'd0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = NCH - 1; i >= 0; i--) begin
      hi_idx_s   = (elig_s[i] && (3'(i) > last_r)) ? 3'(i) : hi_idx_s;
      hi_found_s = hi_found_s | (elig_s[i] && (3'(i) > last_r));
      lo_idx_s   = elig_s[i] ? 3'(i) : lo_idx_s;
      any_elig_s = any_elig_s | elig_s[i];
    end
    win_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // Winner one-hot, winner data mux and the grant qualified by output availability.
  always_comb begin
    win_onehot_s = {NCH{1'b0}};
    win_data_s   = 32'd0;
    for (int i = 0; i < NCH; i++) begin
      win_onehot_s[i] = any_elig_s && (3'(i) == win_idx_s);
      win_data_s      = win_data_s | ({32{win_onehot_s[i]}} & hold_r[i]);
    end
    grant_s     = any_elig_s && ((state_r == ST_IDLE) || out_ready);
    grant_vec_s = grant_s ? win_onehot_s : {NCH{1'b0}};
    upd_s       = ch_update_in & reg_chen;
    // A granted channel hands its old word out this edge, so a coincident update is not an overrun.
    ovf_set_s   = upd_s & pending_r & ~grant_vec_s;
  end

  // Per-channel hold registers and pending bits.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      pending_r <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        hold_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!reg_chen[i]) begin
          pending_r[i] <= 1'b0;
        end else if (upd_s[i]) begin
          pending_r[i] <= 1'b1;
          hold_r[i]    <= ch_data_in[32*i +: 32];
        end else if (grant_vec_s[i]) begin
          pending_r[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overrun flags; a set in the same cycle as a clear wins.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      ovf_r <= {NCH{1'b0}};
    end else begin
      ovf_r <= (ovf_r & ~reg_ovfclr) | ovf_set_s;
    end
  end

  // Output FSM and output word register.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      state_r    <= ST_IDLE;
      out_data_r <= 32'd0;
      out_ch_r   <= 3'd0;
      last_r     <= LAST_RST;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r    <= ST_VALID;
            out_data_r <= win_data_s;
            out_ch_r   <= win_idx_s;
            last_r     <= win_idx_s;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            if (grant_s) begin
              out_data_r <= win_data_s;
              out_ch_r   <= win_idx_s;
              last_r     <= win_idx_s;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = (state_r == ST_VALID);
  assign ovf_flags = ovf_r;
  assign irq       = |ovf_r;

endmodule
